// File: rtl/pe_pulse_rx_pkg.sv
// Shared types and sizing helpers for the PE pulse-train receiver.
package pe_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DRAIN
  } rx_state_t;

  // One extra bit over the row index so a full column of rows fits.
  function automatic int unsigned cnt_w(input int unsigned wid_x);
    return wid_x + 1;
  endfunction

  function automatic int unsigned num_beats(input int unsigned col, input int unsigned lanes);
    return col / lanes;
  endfunction

endpackage

// File: rtl/pe_pulse_rx_col_counter.sv
// Per-column saturating pulse counter; clr_load restarts the count with this cycle's pulse.
module pe_col_counter #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_load,
  input  logic             en,
  input  logic             pulse,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic at_max;

  always_comb begin
    at_max = (cnt == '1);
    sat    = en && !clr_load && pulse && at_max;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr_load) begin
      cnt <= CNT_W'(pulse);
    end else if (en && pulse && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pe_pulse_rx.sv
// Counts per-column pulses over a compute window, then streams the counts
// downstream LANES columns per beat over valid/ready.
module pe_pulse_rx
  import pe_rx_pkg::*;
#(
  parameter int unsigned WID_X   = 6,
  parameter int unsigned WID_Y   = 8,
  parameter int unsigned COL     = 2**WID_Y,
  parameter int unsigned LANES   = 8,
  parameter int unsigned MAX_WIN = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [COL-1:0]                 col_pulse,
  input  logic                           win_start,
  input  logic                           win_end,
  output logic [LANES*cnt_w(WID_X)-1:0]  out_data,
  output logic [WID_Y-1:0]               out_col_base,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           rx_done,
  output logic                           err_sat,
  output logic                           err_timeout,
  output logic                           err_overrun
);

  localparam int unsigned CNT_W     = cnt_w(WID_X);
  localparam int unsigned NUM_BEATS = num_beats(COL, LANES);
  localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned TMR_W     = $clog2(MAX_WIN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(MAX_WIN);

  rx_state_t         state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  logic [TMR_W-1:0]  timer_q;
  logic [CNT_W-1:0]  cnt_arr [COL];
  logic [COL-1:0]    sat_vec;
  logic [WID_Y-1:0]  col_base;

  logic clr_load, cnt_en, drain_entry, timeout_hit, beat_adv, last_accept, is_last;

  for (genvar k = 0; k < COL; k++) begin : g_col
    pe_col_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr_load (clr_load),
      .en       (cnt_en),
      .pulse    (col_pulse[k]),
      .cnt      (cnt_arr[k]),
      .sat      (sat_vec[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_load    = 1'b0;
    cnt_en      = 1'b0;
    drain_entry = 1'b0;
    timeout_hit = 1'b0;
    beat_adv    = 1'b0;
    last_accept = 1'b0;
    out_valid   = 1'b0;
    busy        = (state_q != IDLE);
    is_last     = (beat_q == LAST_BEAT);
    unique case (state_q)
      IDLE: begin
        if (win_start) begin
          clr_load = 1'b1;
          if (win_end) begin
            state_d     = DRAIN;
            drain_entry = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        cnt_en = 1'b1;
        if (win_end) begin
          state_d     = DRAIN;
          drain_entry = 1'b1;
        end else if (timer_q == TMR_MAX) begin
          state_d     = DRAIN;
          drain_entry = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          beat_adv = 1'b1;
          if (is_last) begin
            state_d     = IDLE;
            last_accept = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_last = out_valid && is_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q     <= '0;
      beat_q      <= '0;
      err_sat     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      rx_done     <= 1'b0;
    end else begin
      rx_done     <= last_accept;
      err_overrun <= win_start && (state_q != IDLE);
      if (clr_load) begin
        timer_q     <= TMR_W'(1);
        err_sat     <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (cnt_en && !drain_entry) begin
          timer_q <= timer_q + TMR_W'(1);
        end
        if (|sat_vec) begin
          err_sat <= 1'b1;
        end
        if (timeout_hit) begin
          err_timeout <= 1'b1;
        end
      end
      if (drain_entry) begin
        beat_q <= '0;
      end else if (beat_adv) begin
        beat_q <= is_last ? '0 : beat_q + BEAT_W'(1);
      end
    end
  end

  // Counters are frozen outside COUNT, so a combinational lane mux is stable under stalls.
  always_comb begin
    col_base = WID_Y'(beat_q) * WID_Y'(LANES);
    out_data = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      out_data[l*CNT_W +: CNT_W] = cnt_arr[col_base + WID_Y'(l)];
    end
    out_col_base = col_base;
  end

endmodule

// File: tb/tb_pe_pulse_rx.sv
// Scoreboard bench for pe_pulse_rx: a frame-level count model feeds an expected-beat queue.
module tb_pe_pulse_rx;

  localparam int unsigned WID_X   = 6;
  localparam int unsigned WID_Y   = 8;
  localparam int unsigned COL     = 256;
  localparam int unsigned LANES   = 8;
  localparam int unsigned MAX_WIN = 200;
  localparam int unsigned CNT_W   = WID_X + 1;
  localparam int unsigned CMAX    = (1 << CNT_W) - 1;
  localparam int unsigned NB      = COL / LANES;
  localparam int unsigned DW      = LANES * CNT_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [COL-1:0]  col_pulse;
  logic            win_start, win_end;
  logic [DW-1:0]   out_data;
  logic [WID_Y-1:0] out_col_base;
  logic            out_valid, out_ready, out_last;
  logic            busy, rx_done, err_sat, err_timeout, err_overrun;

  pe_pulse_rx #(
    .WID_X   (WID_X),
    .WID_Y   (WID_Y),
    .COL     (COL),
    .LANES   (LANES),
    .MAX_WIN (MAX_WIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .col_pulse    (col_pulse),
    .win_start    (win_start),
    .win_end      (win_end),
    .out_data     (out_data),
    .out_col_base (out_col_base),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .rx_done      (rx_done),
    .err_sat      (err_sat),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    data;
    logic [WID_Y-1:0] base;
    logic             last;
    logic             esat;
    logic             etmo;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned sum [COL];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [COL-1:0] pulse_vec(input int pmode, input int i);
    logic [COL-1:0] v;
    v = '0;
    case (pmode)
      1: begin
        v[0]     = (i < 5);
        v[9]     = (i < 36);
        v[COL-1] = (i == 0);
      end
      2: v[3] = (i < 130);
      3: v = '1;
      default:
        for (int unsigned w = 0; w < COL / 32; w++) v[w*32 +: 32] = $urandom & $urandom;
    endcase
    return v;
  endfunction

  function automatic logic ready_val(input int rmode, input int cyc);
    case (rmode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Expected beats come straight from per-column pulse totals, clipped at the counter ceiling.
  task automatic push_frame(input logic tmo);
    beat_t e;
    logic  any_sat;
    any_sat = 1'b0;
    for (int unsigned k = 0; k < COL; k++) if (sum[k] > CMAX) any_sat = 1'b1;
    for (int unsigned b = 0; b < NB; b++) begin
      e.data = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        int unsigned c;
        c = sum[b*LANES + l];
        if (c > CMAX) c = CMAX;
        e.data[l*CNT_W +: CNT_W] = CNT_W'(c);
      end
      e.base = WID_Y'(b * LANES);
      e.last = (b == NB - 1);
      e.esat = any_sat;
      e.etmo = tmo;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_frame(input int pmode, input int end_req, input int rmode,
                           input int ovr_cnt, input int ovr_drn, input int rst_at);
    logic [COL-1:0] v;
    int  len, cyc, bound;
    logic has_end, done;
    has_end = (end_req <= int'(MAX_WIN));
    len     = has_end ? end_req : int'(MAX_WIN);
    for (int unsigned k = 0; k < COL; k++) sum[k] = 0;

    for (int i = 0; i <= len; i++) begin
      @(posedge clk); #1;
      win_start = (i == 0) || (ovr_cnt > 0 && i == ovr_cnt);
      win_end   = has_end && (i == len);
      v         = pulse_vec(pmode, i);
      col_pulse = v;
      out_ready = 1'($urandom_range(0, 1));
      for (int unsigned k = 0; k < COL; k++) if (v[k]) sum[k]++;
      @(negedge clk);
      if (i == 1) begin
        check("count_busy", 64'(busy), 64'd1);
        check("no_overrun_on_open", 64'(err_overrun), 64'd0);
      end
      if (ovr_cnt > 0 && i == ovr_cnt + 1) check("overrun_count", 64'(err_overrun), 64'd1);
      if (i == len) check("no_early_valid", 64'(out_valid), 64'd0);
    end
    push_frame(!has_end);

    cyc   = 0;
    done  = 1'b0;
    bound = int'(NB) * 8 + 20;
    while (!done && cyc < bound) begin
      @(posedge clk); #1;
      win_end   = 1'b0;
      win_start = (cyc == ovr_drn);
      col_pulse = pulse_vec(0, cyc);
      if (cyc == rst_at) begin
        rst       = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
      end else begin
        out_ready = ready_val(rmode, cyc);
      end
      @(negedge clk);
      if (cyc == 0) check("first_beat_latency", 64'(out_valid), 64'd1);
      if (ovr_drn >= 0 && cyc == ovr_drn + 1) check("overrun_drain", 64'(err_overrun), 64'd1);
      if (cyc == rst_at) begin
        @(posedge clk); #1;
        rst       = 1'b0;
        win_start = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rx_done", 64'(rx_done), 64'd0);
        check("rst_err_sat", 64'(err_sat), 64'd0);
        done = 1'b1;
      end else if (!busy) begin
        done = 1'b1;
      end
      cyc++;
    end
    if (!done) check("drain_bound", 64'(busy), 64'd0);
    win_start = 1'b0;
  endtask

  // Monitor: pops one expected beat per handshake, checks stall stability and rx_done timing.
  logic             stall_q = 1'b0;
  logic             rx_pend = 1'b0;
  logic [DW-1:0]    hold_data;
  logic [WID_Y-1:0] hold_base;
  logic             hold_last;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_q = 1'b0;
      rx_pend = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(hold_data));
        check("hold_base", 64'(out_col_base), 64'(hold_base));
        check("hold_last", 64'(out_last), 64'(hold_last));
      end
      if (rx_pend || rx_done) check("rx_done", 64'(rx_done), 64'(rx_pend));
      rx_pend = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_queue_empty", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(out_data), 64'(e.data));
          check("beat_base", 64'(out_col_base), 64'(e.base));
          check("beat_last", 64'(out_last), 64'(e.last));
          check("beat_err_sat", 64'(err_sat), 64'(e.esat));
          check("beat_err_timeout", 64'(err_timeout), 64'(e.etmo));
          rx_pend = e.last;
        end
      end
      stall_q   = out_valid && !out_ready;
      hold_data = out_data;
      hold_base = out_col_base;
      hold_last = out_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, oc, od;
    rst       = 1'b1;
    col_pulse = '0;
    win_start = 1'b0;
    win_end   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_last", 64'(out_last), 64'd0);
    check("reset_rx_done", 64'(rx_done), 64'd0);
    check("reset_err_sat", 64'(err_sat), 64'd0);
    check("reset_err_timeout", 64'(err_timeout), 64'd0);
    check("reset_err_overrun", 64'(err_overrun), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(1, 40, 0, 0, -1, -1);                    // basic: cols 0/9/255
    run_frame(0, 30, 1, 5, 2, -1);                     // backpressure 1-0-0-1, overruns
    run_frame(2, 140, 2, 0, -1, -1);                   // col 3 saturates
    run_frame(0, int'(MAX_WIN) + 50, 0, 0, -1, -1);    // forced close
    run_frame(3, 0, 0, 0, -1, -1);                     // single-cycle window, all ones
    run_frame(0, 20, 0, 0, -1, 10);                    // reset at beat 10
    run_frame(0, 10, 0, 0, -1, -1);                    // fresh frame after reset
    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(0, 60);
      oc  = (len >= 3 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len - 2) : 0;
      od  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1;
      run_frame(0, len, 2, oc, od, -1);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
